// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RISC-V
// width encodings and writeback-mux selects.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // True when the width encoding is legal for this direction and the byte
  // offset is naturally aligned for that width.
  function automatic logic req_ok(input logic       we,
                                  input logic [2:0] f3,
                                  input logic [1:0] lo);
    case (f3)
      F3_B:    return 1'b1;
      F3_H:    return !lo[0];
      F3_W:    return lo == 2'b00;
      F3_BU:   return !we;
      F3_HU:   return !we && !lo[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store data replication and strobes, load lane
// extraction with sign/zero extension. Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_strb,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    st_wdata = st_data;
    st_strb  = 4'b1111;
    case (st_funct3)
      F3_B: begin
        st_wdata = {4{st_data[7:0]}};
        st_strb  = 4'b0001 << st_lo;
      end
      F3_H: begin
        st_wdata = {2{st_data[15:0]}};
        st_strb  = 4'b0011 << st_lo;
      end
      default: ;
    endcase
  end

  assign shifted = ld_word >> {ld_lo, 3'b000};

  always_comb begin
    ld_data = ld_word;
    case (ld_funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   ld_data = {24'd0, shifted[7:0]};
      F3_HU:   ld_data = {16'd0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: one outstanding access to a handshaked data memory,
// stalling the core until a single-cycle RESP with done and error flags.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int N              = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic         req_we,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] wdata,
  output logic         stall,
  output logic [N-1:0] rdata,
  output logic         done,
  output logic         err_misalign,
  output logic         err_bus,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic [3:0]   mem_wstrb,
  input  logic         mem_ready,
  input  logic [N-1:0] mem_rdata
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t       state;
  logic [7:0]   to_cnt;
  logic [2:0]   funct3_q;
  logic [1:0]   lo_q;
  logic [N-1:0] st_wdata;
  logic [3:0]   st_strb;
  logic [N-1:0] ld_data;
  logic         legal;

  assign legal = req_ok(req_we, funct3, addr[1:0]);
  assign stall = (state == IDLE && req_valid) || (state == ACCESS);

  // Store side steers the incoming request; load side uses the latched
  // request against the word returned by memory.
  lsu_lane_align u_align (
    .st_funct3 (funct3),
    .st_lo     (addr[1:0]),
    .st_data   (wdata),
    .st_wdata  (st_wdata),
    .st_strb   (st_strb),
    .ld_funct3 (funct3_q),
    .ld_lo     (lo_q),
    .ld_word   (mem_rdata),
    .ld_data   (ld_data)
  );

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // blocking assignments would make later statements observe new state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      to_cnt       <= '0;
      funct3_q     <= '0;
      lo_q         <= '0;
      rdata        <= '0;
      done         <= 1'b0;
      err_misalign <= 1'b0;
      err_bus      <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (legal) begin
              funct3_q  <= funct3;
              lo_q      <= addr[1:0];
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {addr[N-1:2], 2'b00};
              mem_wdata <= st_wdata;
              mem_wstrb <= req_we ? st_strb : 4'b0000;
              to_cnt    <= '0;
              state     <= ACCESS;
            end else begin
              err_misalign <= 1'b1;
              rdata        <= '0;
              done         <= 1'b1;
              state        <= RESP;
            end
          end
        end
        ACCESS: begin
          // mem_we/addr/wdata/wstrb are untouched here, so they stay stable.
          if (mem_ready) begin
            if (!mem_we) rdata <= ld_data;
            mem_req <= 1'b0;
            done    <= 1'b1;
            state   <= RESP;
          end else if (to_cnt == TO_LAST) begin
            err_bus <= 1'b1;
            rdata   <= '0;
            mem_req <= 1'b0;
            done    <= 1'b1;
            state   <= RESP;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        RESP: begin
          err_misalign <= 1'b0;
          err_bus      <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed requests push expected memory
// transactions and responses; a memory responder and a done monitor check them.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall;
  logic [31:0] rdata;
  logic        done;
  logic        err_misalign;
  logic        err_bus;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  lsu_mem_ctrl #(.N(32), .TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .stall        (stall),
    .rdata        (rdata),
    .done         (done),
    .err_misalign (err_misalign),
    .err_bus      (err_bus),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        bus;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rword;
    int          wait_n;
  } mem_t;

  resp_t resp_q[$];
  mem_t  mem_q[$];
  bit    manual_mem = 1'b0;
  int    tests = 0;
  int    fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: checks request fields every ACCESS cycle and raises
  // mem_ready after the programmed number of wait cycles.
  int   acc_cyc = 0;
  mem_t cur;
  always @(negedge clk) begin
    if (!manual_mem) begin
      if (mem_req) begin
        if (acc_cyc == 0) begin
          if (mem_q.size() == 0) begin
            check("unexpected_mem_req", 32'(mem_req), 32'd0);
            cur = '{we: 1'b0, addr: 32'd0, wdata: 32'd0, strb: 4'd0, rword: 32'd0, wait_n: 0};
          end else begin
            cur = mem_q.pop_front();
          end
        end
        check("mem_we", 32'(mem_we), 32'(cur.we));
        check("mem_addr", mem_addr, cur.addr);
        check("mem_wstrb", 32'(mem_wstrb), 32'(cur.strb));
        if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
        mem_ready = (acc_cyc == cur.wait_n);
        mem_rdata = mem_ready ? cur.rword : 32'h5A5A_5A5A;
        acc_cyc++;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
        acc_cyc   = 0;
      end
    end
  end

  // Response monitor: every done pulse is matched to the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (resp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        check("rdata", rdata, r.rdata);
        check("err_misalign", 32'(err_misalign), 32'(r.mis));
        check("err_bus", 32'(err_bus), 32'(r.bus));
        check("resp_mem_req", 32'(mem_req), 32'd0);
        check("resp_stall", 32'(stall), 32'd0);
      end
    end
  end

  task automatic expect_mem(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] strb, input logic [31:0] rword, input int wait_n);
    mem_q.push_back('{we: we, addr: a, wdata: wd, strb: strb, rword: rword, wait_n: wait_n});
  endtask

  // Drive one request, hold it while stalled, and count the stall cycles.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rdata,
                       input logic exp_mis, input logic exp_bus, input int exp_stall);
    int n;
    resp_q.push_back('{rdata: exp_rdata, mis: exp_mis, bus: exp_bus});
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    n = 0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (!stall) break;
      n++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("stall_cycles", 32'(n), 32'(exp_stall));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_rdata", rdata, 32'd0);
    check("reset_flags", {28'd0, done, err_misalign, err_bus, mem_req}, 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    check("reset_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);

    // Loads: word with one wait cycle, byte/half lanes with sign/zero extension.
    expect_mem(1'b0, 32'h0000_0100, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1);
    issue(1'b0, F3_W, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 3);
    expect_mem(1'b0, 32'h0000_1000, 32'h0, 4'b0000, 32'h8012_3456, 0);
    issue(1'b0, F3_B, 32'h0000_1003, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b0, 2);
    expect_mem(1'b0, 32'h0000_1000, 32'h0, 4'b0000, 32'h8012_3456, 2);
    issue(1'b0, F3_BU, 32'h0000_1003, 32'h0, 32'h0000_0080, 1'b0, 1'b0, 4);

    // Store half to upper lane; rdata keeps the last load value.
    expect_mem(1'b1, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100, 32'h0, 0);
    issue(1'b1, F3_H, 32'h0000_2002, 32'h1234_BEEF, 32'h0000_0080, 1'b0, 1'b0, 2);

    expect_mem(1'b0, 32'h0000_0100, 32'h0, 4'b0000, 32'h8001_7FFF, 0);
    issue(1'b0, F3_H, 32'h0000_0102, 32'h0, 32'hFFFF_8001, 1'b0, 1'b0, 2);
    expect_mem(1'b0, 32'h0000_0100, 32'h0, 4'b0000, 32'h1234_8765, 1);
    issue(1'b0, F3_HU, 32'h0000_0100, 32'h0, 32'h0000_8765, 1'b0, 1'b0, 3);

    expect_mem(1'b1, 32'h0000_0040, 32'hABAB_ABAB, 4'b0010, 32'h0, 0);
    issue(1'b1, F3_B, 32'h0000_0041, 32'h0000_00AB, 32'h0000_8765, 1'b0, 1'b0, 2);
    // Three wait cycles: one short of the timeout of 4.
    expect_mem(1'b1, 32'h0000_0050, 32'hCAFE_F00D, 4'b1111, 32'h0, 3);
    issue(1'b1, F3_W, 32'h0000_0050, 32'hCAFE_F00D, 32'h0000_8765, 1'b0, 1'b0, 5);

    // Illegal or misaligned: no memory request, error response clears rdata.
    issue(1'b0, F3_W, 32'h0000_1001, 32'h0, 32'h0, 1'b1, 1'b0, 1);
    issue(1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 1'b1, 1'b0, 1);
    issue(1'b1, F3_BU, 32'h0000_0000, 32'h55, 32'h0, 1'b1, 1'b0, 1);
    issue(1'b1, F3_H, 32'h0000_0003, 32'h55, 32'h0, 1'b1, 1'b0, 1);

    // Timeout: exactly four ACCESS cycles without mem_ready.
    expect_mem(1'b0, 32'h0000_3000, 32'h0, 4'b0000, 32'h0, 1000);
    issue(1'b0, F3_W, 32'h0000_3000, 32'h0, 32'h0, 1'b0, 1'b1, 5);

    // Reset during the second ACCESS cycle, then a late mem_ready.
    manual_mem = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; funct3 = F3_W; addr = 32'h0000_0400;
    mem_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_req_a1", 32'(mem_req), 32'd1);
    @(negedge clk);
    check("rst_mid_req_a2", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_stall", 32'(stall), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_outs", {28'd0, done, err_misalign, err_bus, mem_req}, 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    check("rst_mid_mem", {mem_addr[27:0], mem_wstrb} ^ mem_wdata ^ {31'd0, mem_we}, 32'd0);
    repeat (2) @(negedge clk) check("rst_mid_no_done", 32'(done), 32'd0);
    manual_mem = 1'b0;

    // Recovery after reset.
    expect_mem(1'b0, 32'h0000_0200, 32'h0, 4'b0000, 32'h1122_3344, 0);
    issue(1'b0, F3_W, 32'h0000_0200, 32'h0, 32'h1122_3344, 1'b0, 1'b0, 2);

    repeat (3) @(negedge clk);
    check("resp_queue_empty", 32'(resp_q.size()), 32'd0);
    check("mem_queue_empty", 32'(mem_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
